// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_OPC_W   = 4;
    localparam int unsigned DEF_INSTR_W = 2 * DEF_OPC_W;

    localparam logic [DEF_OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [DEF_OPC_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2,
        StDone = 2'd3
    } fetch_state_t;

    // Instruction word layout: [7:4] function, [3:0] value.
    function automatic logic [DEF_OPC_W-1:0] instr_func(input logic [DEF_INSTR_W-1:0] word);
        return word[DEF_INSTR_W-1 -: DEF_OPC_W];
    endfunction

    function automatic logic [DEF_OPC_W-1:0] instr_value(input logic [DEF_INSTR_W-1:0] word);
        return word[DEF_OPC_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load port and presented-instruction bus of the fetch stage.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned OPC_W  = 4
);
    logic                 load_valid;
    logic [ADDR_W-1:0]    load_addr;
    logic [2*OPC_W-1:0]   load_data;
    logic                 load_ready;
    logic [OPC_W-1:0]     memoryFunction;
    logic [OPC_W-1:0]     memoryValue;
    logic [ADDR_W-1:0]    outPC;
    logic                 fetch_valid;

    modport master (
        output load_valid, load_addr, load_data,
        input  load_ready, memoryFunction, memoryValue, outPC, fetch_valid
    );

    modport slave (
        input  load_valid, load_addr, load_data,
        output load_ready, memoryFunction, memoryValue, outPC, fetch_valid
    );
endinterface

// File: rtl/prog_ram.sv
// Program RAM: synchronous write, asynchronous read (LUT RAM friendly).
module prog_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: run/step/halt sequencer presenting registered {function, value} pairs.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OPC_W  = DEF_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    output logic [1:0]        state,
    instr_fetch_if.slave      bus
);
    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
    logic [OPC_W-1:0]    func_q, func_d;
    logic [OPC_W-1:0]    value_q, value_d;
    logic                valid_q, valid_d;

    logic                do_fetch;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [2*OPC_W-1:0]  rdata;
    logic                ram_we;
    logic                halt_presented;
    logic [OPC_W-1:0]    rd_func;

    assign ram_we = (state_q == StIdle) && bus.load_valid;

    prog_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(2 * OPC_W)
    ) u_prog_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(bus.load_addr),
        .wdata(bus.load_data),
        .raddr(fetch_addr),
        .rdata(rdata)
    );

    assign rd_func        = instr_func(rdata);
    assign halt_presented = valid_q && (func_q == OPC_HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_pc_d   = out_pc_q;
        func_d     = OPC_NOP;
        value_d    = '0;
        valid_d    = 1'b0;
        do_fetch   = 1'b0;
        fetch_addr = pc_q;

        unique case (state_q)
            StIdle: begin
                // A pending load blocks run/step for this cycle.
                if (!bus.load_valid) begin
                    if (run) begin
                        do_fetch   = 1'b1;
                        fetch_addr = '0;
                        state_d    = StRun;
                    end else if (step) begin
                        do_fetch = 1'b1;
                        state_d  = StStep;
                    end
                end
            end
            StRun: begin
                if (halt_req) begin
                    state_d = StIdle;
                end else if (halt_presented) begin
                    state_d = StDone;
                end else begin
                    do_fetch = 1'b1;
                end
            end
            StStep: begin
                if (halt_req) begin
                    state_d = StIdle;
                end else if (halt_presented) begin
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (run) begin
                    do_fetch   = 1'b1;
                    fetch_addr = '0;
                    state_d    = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_fetch) begin
            func_d   = rd_func;
            value_d  = instr_value(rdata);
            valid_d  = 1'b1;
            out_pc_d = fetch_addr;
            // PC parks on a halt so outPC keeps the halt address.
            pc_d     = (rd_func == OPC_HALT) ? fetch_addr : fetch_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            out_pc_q <= '0;
            func_q   <= OPC_NOP;
            value_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            func_q   <= func_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
        end
    end

    assign state              = state_q;
    assign bus.load_ready     = (state_q == StIdle);
    assign bus.memoryFunction = func_q;
    assign bus.memoryValue    = value_q;
    assign bus.outPC          = out_pc_q;
    assign bus.fetch_valid    = valid_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, corner sequences, random vs. model.
module tb_instr_fetch;
    logic       clk = 1'b0;
    logic       rst, run, step, halt_req;
    logic [1:0] state;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .step    (step),
        .halt_req(halt_req),
        .state   (state),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst;
        bit         lv;
        logic [3:0] a;
        logic [7:0] d;
        bit         run;
        bit         step;
        bit         halt;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (integer-valued, behavioural).
    int         m_st;
    int         m_pc;
    int         m_out;
    int         m_f;
    int         m_v;
    bit         m_valid;
    logic [7:0] m_mem [16];

    function automatic logic [15:0] pk(int st, int pc, int f, int v, bit fv, bit rdy);
        logic [15:0] r;
        r = {st[1:0], pc[3:0], f[3:0], v[3:0], fv, rdy};
        return r;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {state, bus.outPC, bus.memoryFunction, bus.memoryValue, bus.fetch_valid,
                bus.load_ready};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d pc=%0h f=%0h v=%0h fv=%b rdy=%b, expected st=%0d pc=%0h f=%0h v=%0h fv=%b rdy=%b",
                     name, act[15:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     exp[15:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lv, input logic [3:0] a, input logic [7:0] d,
                         input bit r, input bit s, input bit h);
        bus.load_valid = lv;
        bus.load_addr  = a;
        bus.load_data  = d;
        run            = r;
        step           = s;
        halt_req       = h;
    endtask

    task automatic sync_reset();
        drive(0, 4'h0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        drive(1, a, d, 0, 0, 0);
        tick();
        drive(0, 4'h0, 8'h00, 0, 0, 0);
    endtask

    function automatic void addv(bit r, bit lv, logic [3:0] a, logic [7:0] d,
                                 bit rn, bit s, bit h, logic [15:0] e);
        vec_t v;
        v = '{rst: r, lv: lv, a: a, d: d, run: rn, step: s, halt: h, exp: e};
        tbl.push_back(v);
    endfunction

    // One clock edge of the architectural behaviour.
    task automatic mdl_edge(input bit lv, input logic [3:0] a, input logic [7:0] d,
                            input bit r, input bit s, input bit h);
        bit was_halt;
        int fetch_at;
        was_halt = m_valid && (m_f == 15);
        fetch_at = -1;
        if (m_st == 0) begin
            if (lv) m_mem[a] = d;
            else if (r) begin fetch_at = 0; m_st = 1; end
            else if (s) begin fetch_at = m_pc; m_st = 2; end
        end else if (m_st == 1 || m_st == 2) begin
            if (h) m_st = 0;
            else if (was_halt) m_st = 3;
            else if (m_st == 1) fetch_at = m_pc;
            else m_st = 0;
        end else if (r) begin
            fetch_at = 0;
            m_st = 1;
        end
        m_f = 0;
        m_v = 0;
        m_valid = 0;
        if (fetch_at >= 0) begin
            m_out   = fetch_at;
            m_f     = int'(m_mem[fetch_at][7:4]);
            m_v     = int'(m_mem[fetch_at][3:0]);
            m_valid = 1;
            m_pc    = (m_f == 15) ? fetch_at : (fetch_at + 1) % 16;
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        drive(0, 4'h0, 8'h00, 0, 0, 0);

        // ---------------- vector table ----------------
        addv(1, 0, 4'h0, 8'h00, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 1, 4'h0, 8'h13, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 1, 4'h1, 8'h25, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 1, 4'h2, 8'hF0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 1, 4'h4, 8'h33, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 1, 0, 0, pk(1, 0, 1, 3, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 1, 2, 5, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 2, 15, 0, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(3, 2, 0, 0, 0, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(3, 2, 0, 0, 0, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 1, 0, pk(3, 2, 0, 0, 0, 0));
        addv(0, 1, 4'h4, 8'h77, 0, 0, 0, pk(3, 2, 0, 0, 0, 0));
        addv(0, 0, 4'h0, 8'h00, 1, 0, 0, pk(1, 0, 1, 3, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 1, pk(0, 0, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 0, 1, 0, pk(2, 1, 2, 5, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(0, 1, 0, 0, 0, 1));
        addv(0, 1, 4'h3, 8'h4A, 1, 0, 0, pk(0, 1, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 0, 1, 0, pk(2, 2, 15, 0, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(3, 2, 0, 0, 0, 0));
        addv(1, 0, 4'h0, 8'h00, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 1, 4'h2, 8'h3C, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 1, 0, 0, pk(1, 0, 1, 3, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 1, 2, 5, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 2, 3, 12, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 3, 4, 10, 1, 0));
        addv(0, 1, 4'h4, 8'h77, 0, 0, 1, pk(0, 3, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 0, 1, 0, pk(2, 4, 3, 3, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 1, pk(0, 4, 0, 0, 0, 1));
        addv(0, 0, 4'h0, 8'h00, 1, 0, 1, pk(1, 0, 1, 3, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 1, 2, 5, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 0, pk(1, 2, 3, 12, 1, 0));
        addv(0, 0, 4'h0, 8'h00, 0, 0, 1, pk(0, 2, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            drive(tbl[i].lv, tbl[i].a, tbl[i].d, tbl[i].run, tbl[i].step, tbl[i].halt);
            tick();
            chk($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
        end
        rst = 1'b0;

        // ---------------- wrap run then halt_req ----------------
        sync_reset();
        for (int i = 0; i < 16; i++) load(4'(i), 8'h11);
        drive(0, 4'h0, 8'h00, 1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            run = 1'b0;
            chk($sformatf("wrap%0d", k), dut_vec(), pk(1, k % 16, 1, 1, 1, 0));
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("wrap_halt", dut_vec(), pk(0, 3, 0, 0, 0, 1));

        // ---------------- halt_req beats fetched halt opcode ----------------
        load(4'h0, 8'h12);
        load(4'h1, 8'hF0);
        drive(0, 4'h0, 8'h00, 1, 0, 0);
        tick();
        chk("prio_run", dut_vec(), pk(1, 0, 1, 2, 1, 0));
        drive(0, 4'h0, 8'h00, 0, 0, 1);
        tick();
        chk("prio_idle", dut_vec(), pk(0, 0, 0, 0, 0, 1));
        drive(0, 4'h0, 8'h00, 0, 1, 0);
        tick();
        chk("prio_step_halt", dut_vec(), pk(2, 1, 15, 0, 1, 0));
        drive(0, 4'h0, 8'h00, 0, 0, 0);
        tick();
        chk("prio_done", dut_vec(), pk(3, 1, 0, 0, 0, 0));

        // ---------------- async reset mid-RUN at PC 7 ----------------
        sync_reset();
        for (int i = 0; i < 16; i++) load(4'(i), {4'h1, 4'(i)});
        drive(0, 4'h0, 8'h00, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            run = 1'b0;
        end
        chk("pre_rst_pc7", dut_vec(), pk(1, 7, 1, 7, 1, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", dut_vec(), pk(0, 0, 0, 0, 0, 1));
        tick();
        rst = 1'b0;
        drive(0, 4'h0, 8'h00, 1, 0, 0);
        tick();
        run = 1'b0;
        chk("rerun_pc0", dut_vec(), pk(1, 0, 1, 0, 1, 0));
        tick();
        chk("rerun_pc1", dut_vec(), pk(1, 1, 1, 1, 1, 0));

        // ---------------- two steps five cycles apart ----------------
        sync_reset();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step = (c == 0 || c == 5);
            tick();
            step = 1'b0;
            if (bus.fetch_valid) pulses++;
            if (c == 0) chk("step0", dut_vec(), pk(2, 0, 1, 0, 1, 0));
            if (c == 1) chk("step0_idle", dut_vec(), pk(0, 0, 0, 0, 0, 1));
            if (c == 5) chk("step1", dut_vec(), pk(2, 1, 1, 1, 1, 0));
            if (c == 6) chk("step1_idle", dut_vec(), pk(0, 1, 0, 0, 0, 1));
        end
        chk("step_pulses", 16'(pulses), 16'd2);

        // ---------------- random vs. reference model ----------------
        sync_reset();
        m_st = 0; m_pc = 0; m_out = 0; m_f = 0; m_v = 0; m_valid = 0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            m_mem[i] = w;
            load(4'(i), w);
        end
        for (int c = 0; c < 400; c++) begin
            bit         lv, r, s, h;
            logic [3:0] a;
            logic [7:0] d;
            lv = ($urandom % 4) == 0;
            a  = 4'($urandom);
            d  = (($urandom % 5) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom);
            r  = ($urandom % 10) == 0;
            s  = ($urandom % 5) == 0;
            h  = ($urandom % 12) == 0;
            drive(lv, a, d, r, s, h);
            tick();
            mdl_edge(lv, a, d, r, s, h);
            chk($sformatf("rand%0d", c), dut_vec(),
                pk(m_st, m_out, m_f, m_v, m_valid, m_st == 0));
        end
        drive(0, 4'h0, 8'h00, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that feeds the CPU datapath's control unit (UC) and regX input, in place of the free-running PC + Memory pair. Holds a 16-entry, 8-bit program RAM that is loaded through a valid/ready port. Sequences the program under a run/step/halt state machine and presents one registered `{memoryFunction, memoryValue}` pair per executed cycle, with a valid flag.

## Interface
Parameters:
- `ADDR_W`, 4: PC / program address width (16 entries).
- `OPC_W`, 4: width of memoryFunction and memoryValue; instruction word is 2·OPC_W bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load_valid`  in  1: program-write request.
- `load_addr`  in  4: write address.
- `load_data`  in  8: instruction word; `[7:4]` = function, `[3:0]` = value.
- `load_ready`  out  1: write accepted when high.
- `run`  in  1: pulse; start continuous execution from PC 0.
- `step`  in  1: pulse; execute exactly one instruction.
- `halt_req`  in  1: stop execution at the next edge.
- `memoryFunction`  out  4: opcode to UC.
- `memoryValue`  out  4: immediate to regX.
- `outPC`  out  4: address of the instruction currently presented.
- `fetch_valid`  out  1: high for each cycle an instruction is presented for execution.
- `state`  out  2: FSM state, for debug/LEDs.

## Operation
- States: IDLE=0, RUN=1, STEP=2, DONE=3.
- IDLE:
  - `load_ready`=1 (combinational, IDLE only). A write occurs on an edge with `load_valid`=1.
  - `run` → RUN, PC=0.
  - `step` → STEP, presenting mem[PC].
  - If `load_valid` and `run`/`step` are asserted together, the load wins; `run`/`step` is ignored that cycle.
- RUN:
  - Each edge latches mem[PC] into the outputs, sets `fetch_valid`=1, and increments PC.
  - PC wraps 15→0.
- STEP: presents one instruction for one cycle, PC+1, then returns to IDLE.
- Halt opcode:
  - Function 4'hF is presented once with `fetch_valid`=1. PC does not advance.
  - Next edge → DONE.
- DONE:
  - `fetch_valid`=0; outputs forced to NOP (function 4'h0, value 0); `outPC` holds the halt address.
  - `run` → RUN from PC 0. `step` is ignored.
- `halt_req` in RUN/STEP:
  - Next edge → IDLE; outputs NOP; `fetch_valid`=0; PC holds (resumable by `step`).
  - `halt_req` has priority over a halt opcode being fetched that same edge.
- Outside RUN/STEP, outputs are always NOP with `fetch_valid`=0, so UC holds regX/Y/Z.
- `load_valid` outside IDLE is ignored (`load_ready`=0).

## Timing
- Reset values: state IDLE, `outPC`=0, `memoryFunction`=0, `memoryValue`=0, `fetch_valid`=0, `load_ready`=1. RAM contents are not reset.
- Reset mid-RUN: immediate return to IDLE with the above values. RAM is preserved.
- Load latency: written on the accepting edge; readable by a fetch on the next edge.
- `run` sampled high at edge N → at N+1, `outPC`=0, mem[0] presented, `fetch_valid`=1. Thereafter one instruction per cycle.
- `step` at edge N → instruction valid in cycle N+1 only; IDLE at N+2.
- All outputs are registered except `load_ready`.

## Structure
- Package `fetch_pkg`:
  - state enum;
  - `OPC_NOP`=4'h0, `OPC_HALT`=4'hF;
  - `ADDR_W`/`OPC_W` defaults;
  - instruction-word field slices.
- Sub-module `prog_ram`: 16×8, synchronous write, asynchronous read (maps to Quartus MLAB/LUT RAM).
- Top: FSM, PC counter, output registers.

## Test plan
- Reset, then write mem[0..2] = 8'h13, 8'h25, 8'hF0; pulse `run` → next three cycles show outPC 0,1,2 and function/value 1/3, 2/5, F/0 with `fetch_valid`=1; then DONE, NOP, `outPC`=2.
- Fill all 16 entries with 8'h11, `run`, then assert `halt_req` after 20 cycles → outPC sequence wraps 15→0→…; IDLE the cycle after `halt_req`; outputs NOP.
- In IDLE, two `step` pulses, 5 cycles apart → exactly two single-cycle `fetch_valid` pulses at PC 0 then 1.
- Assert `load_valid`+`run` in the same IDLE cycle → write happens, state stays IDLE. Assert `load_valid` during RUN → RAM unchanged, `load_ready`=0.
- Assert `rst` mid-RUN at PC 7 → outputs immediately 0, state IDLE; a following `run` re-executes from PC 0 with the program intact.
